// File: rtl/sram_capture_if.sv
// Debug-register and SRAM-side signal bundle of the debug capture controller.
// The controller drives the master side; the register bank / SRAM sees the slave side.
interface sram_capture_if #(
    parameter int ADDR_W = 10,
    parameter int HOLD_W = 16
);
    logic              arm;
    logic              abort;
    logic              trig_in;
    logic [ADDR_W:0]   n_samples;
    logic [HOLD_W-1:0] holdoff;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] sram_addr;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic [2:0]        state;
    logic [ADDR_W:0]   wr_count;

    modport master (
        input  arm, abort, trig_in, n_samples, holdoff, in_addr,
        output sram_addr, wr_en, busy, done, state, wr_count
    );

    modport slave (
        output arm, abort, trig_in, n_samples, holdoff, in_addr,
        input  sram_addr, wr_en, busy, done, state, wr_count
    );
endinterface

// File: rtl/sram_capture_ctrl.sv
// Debug SRAM capture sequencer: arm, trigger, hold-off, fill n_eff words,
// then return the SRAM address bus to JTAG readback.
module sram_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int HOLD_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    sram_capture_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        HOLDOFF = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);

    state_t            state_q, state_n;
    logic              arm_d, trig_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_n;
    logic [ADDR_W:0]   n_eff_q, n_eff_n;
    logic [ADDR_W:0]   cnt_q, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              wr_en_q;
    logic              arm_rise, trig_rise, busy;

    assign arm_rise  = bus.arm & ~arm_d;
    assign trig_rise = bus.trig_in & ~trig_d;

    always_comb begin
        state_n = state_q;
        hcnt_n  = hcnt_q;
        n_eff_n = n_eff_q;
        cnt_n   = cnt_q;
        addr_n  = addr_q;
        // Every CAPTURE cycle is a real write, so it is counted even when aborted.
        if (state_q == CAPTURE) begin
            cnt_n = cnt_q + 1'b1;
        end
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm_rise) begin
                        if (bus.n_samples == '0 || bus.n_samples > DEPTH_C) begin
                            n_eff_n = DEPTH_C;
                        end else begin
                            n_eff_n = bus.n_samples;
                        end
                        hcnt_n  = bus.holdoff;
                        cnt_n   = '0;
                        addr_n  = '0;
                        state_n = ARMED;
                    end
                end
                ARMED: begin
                    if (trig_rise) begin
                        state_n = (hcnt_q == '0) ? CAPTURE : HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    hcnt_n = hcnt_q - 1'b1;
                    if (hcnt_q == HOLD_W'(1)) begin
                        state_n = CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Address is left on the last word so it never wraps.
                    if (cnt_q == n_eff_q - 1'b1) begin
                        state_n = DONE;
                    end else begin
                        addr_n = addr_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.arm) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            arm_d   <= 1'b0;
            trig_d  <= 1'b0;
            hcnt_q  <= '0;
            n_eff_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_n;
            arm_d   <= bus.arm;
            trig_d  <= bus.trig_in;
            hcnt_q  <= hcnt_n;
            n_eff_q <= n_eff_n;
            cnt_q   <= cnt_n;
            addr_q  <= addr_n;
            wr_en_q <= (state_n == CAPTURE);
        end
    end

    assign busy          = (state_q == ARMED) || (state_q == HOLDOFF) ||
                           (state_q == CAPTURE);
    assign bus.busy      = busy;
    assign bus.done      = (state_q == DONE);
    assign bus.state     = state_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_count  = cnt_q;
    assign bus.sram_addr = busy ? addr_q : bus.in_addr;
endmodule
